// File: rtl/tl_tx_arb.sv
// TLP transmit arbiter: round-robin over P/NP/CPL, gated by flow-control credits.
// Holds one grant per packet and pulses credit consumption on the first granted cycle.
module tl_tx_arb #(
    parameter int HDR_W  = 8,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arb_en_i,
    input  logic              p_req_i,
    input  logic              np_req_i,
    input  logic              cpl_req_i,
    input  logic [DATA_W-1:0] p_dcred_i,
    input  logic [DATA_W-1:0] np_dcred_i,
    input  logic [DATA_W-1:0] cpl_dcred_i,
    input  logic              ph_ok_i,
    input  logic              pd_ok_i,
    input  logic              nph_ok_i,
    input  logic              npd_ok_i,
    input  logic              cplh_ok_i,
    input  logic              cpld_ok_i,
    input  logic              tx_done_i,
    output logic [2:0]        gnt_o,
    output logic              busy_o,
    output logic              ph_consume_v_o,
    output logic [HDR_W-1:0]  ph_consume_dw_o,
    output logic              nph_consume_v_o,
    output logic [HDR_W-1:0]  nph_consume_dw_o,
    output logic              cplh_consume_v_o,
    output logic [HDR_W-1:0]  cplh_consume_dw_o,
    output logic              pd_consume_v_o,
    output logic [DATA_W-1:0] pd_consume_dw_o,
    output logic              npd_consume_v_o,
    output logic [DATA_W-1:0] npd_consume_dw_o,
    output logic              cpld_consume_v_o,
    output logic [DATA_W-1:0] cpld_consume_dw_o
);
    typedef enum logic {IDLE, XFER} state_e;
    localparam logic [1:0] CL_P = 2'd0, CL_NP = 2'd1, CL_CPL = 2'd2;

    state_e            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        win_q, win_d;
    logic [DATA_W-1:0] dcred_q, dcred_d;
    logic              first_q, first_d;

    logic [2:0]        elig;
    logic [1:0]        sel;
    logic [DATA_W-1:0] sel_dcred;
    logic [2:0]        hdr_v, dat_v;

    assign elig[0] = p_req_i   & ph_ok_i   & ((p_dcred_i   == '0) | pd_ok_i);
    assign elig[1] = np_req_i  & nph_ok_i  & ((np_dcred_i  == '0) | npd_ok_i);
    assign elig[2] = cpl_req_i & cplh_ok_i & ((cpl_dcred_i == '0) | cpld_ok_i);

    // Search starts one past the last winner; an unused last_q code behaves as CPL.
    always_comb begin
        sel = CL_P;
        case (last_q)
            CL_P: begin
                if      (elig[1]) sel = CL_NP;
                else if (elig[2]) sel = CL_CPL;
                else              sel = CL_P;
            end
            CL_NP: begin
                if      (elig[2]) sel = CL_CPL;
                else if (elig[0]) sel = CL_P;
                else              sel = CL_NP;
            end
            default: begin
                if      (elig[0]) sel = CL_P;
                else if (elig[1]) sel = CL_NP;
                else              sel = CL_CPL;
            end
        endcase
    end

    always_comb begin
        case (sel)
            CL_NP:   sel_dcred = np_dcred_i;
            CL_CPL:  sel_dcred = cpl_dcred_i;
            default: sel_dcred = p_dcred_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        dcred_d = dcred_q;
        first_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_en_i && (|elig)) begin
                    state_d = XFER;
                    win_d   = sel;
                    dcred_d = sel_dcred;
                    first_d = 1'b1;
                end
            end
            XFER: begin
                if (tx_done_i) begin
                    state_d = IDLE;
                    last_d  = win_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= CL_CPL;
            win_q   <= CL_P;
            dcred_q <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            dcred_q <= dcred_d;
            first_q <= first_d;
        end
    end

    // Outputs decode straight from flops so reset clears them without waiting for a clock.
    assign busy_o = (state_q == XFER);
    assign gnt_o  = busy_o ? (3'b001 << win_q) : 3'b000;
    assign hdr_v  = first_q ? gnt_o : 3'b000;
    assign dat_v  = (dcred_q != '0) ? hdr_v : 3'b000;

    assign ph_consume_v_o    = hdr_v[0];
    assign nph_consume_v_o   = hdr_v[1];
    assign cplh_consume_v_o  = hdr_v[2];
    assign ph_consume_dw_o   = hdr_v[0] ? HDR_W'(1) : '0;
    assign nph_consume_dw_o  = hdr_v[1] ? HDR_W'(1) : '0;
    assign cplh_consume_dw_o = hdr_v[2] ? HDR_W'(1) : '0;

    assign pd_consume_v_o    = dat_v[0];
    assign npd_consume_v_o   = dat_v[1];
    assign cpld_consume_v_o  = dat_v[2];
    assign pd_consume_dw_o   = dat_v[0] ? dcred_q : '0;
    assign npd_consume_dw_o  = dat_v[1] ? dcred_q : '0;
    assign cpld_consume_dw_o = dat_v[2] ? dcred_q : '0;
endmodule

// File: tb/tb_tl_tx_arb.sv
// Directed bench for tl_tx_arb: inputs change on the falling edge, outputs sampled there too.
module tb_tl_tx_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        arb_en_i;
    logic        p_req_i, np_req_i, cpl_req_i;
    logic [11:0] p_dcred_i, np_dcred_i, cpl_dcred_i;
    logic        ph_ok_i, pd_ok_i, nph_ok_i, npd_ok_i, cplh_ok_i, cpld_ok_i;
    logic        tx_done_i;
    logic [2:0]  gnt_o;
    logic        busy_o;
    logic        ph_consume_v_o, nph_consume_v_o, cplh_consume_v_o;
    logic [7:0]  ph_consume_dw_o, nph_consume_dw_o, cplh_consume_dw_o;
    logic        pd_consume_v_o, npd_consume_v_o, cpld_consume_v_o;
    logic [11:0] pd_consume_dw_o, npd_consume_dw_o, cpld_consume_dw_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tl_tx_arb #(.HDR_W(8), .DATA_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en_i(arb_en_i),
        .p_req_i(p_req_i), .np_req_i(np_req_i), .cpl_req_i(cpl_req_i),
        .p_dcred_i(p_dcred_i), .np_dcred_i(np_dcred_i), .cpl_dcred_i(cpl_dcred_i),
        .ph_ok_i(ph_ok_i), .pd_ok_i(pd_ok_i), .nph_ok_i(nph_ok_i), .npd_ok_i(npd_ok_i),
        .cplh_ok_i(cplh_ok_i), .cpld_ok_i(cpld_ok_i), .tx_done_i(tx_done_i),
        .gnt_o(gnt_o), .busy_o(busy_o),
        .ph_consume_v_o(ph_consume_v_o), .ph_consume_dw_o(ph_consume_dw_o),
        .nph_consume_v_o(nph_consume_v_o), .nph_consume_dw_o(nph_consume_dw_o),
        .cplh_consume_v_o(cplh_consume_v_o), .cplh_consume_dw_o(cplh_consume_dw_o),
        .pd_consume_v_o(pd_consume_v_o), .pd_consume_dw_o(pd_consume_dw_o),
        .npd_consume_v_o(npd_consume_v_o), .npd_consume_dw_o(npd_consume_dw_o),
        .cpld_consume_v_o(cpld_consume_v_o), .cpld_consume_dw_o(cpld_consume_dw_o)
    );

    wire [69:0] obs = {gnt_o, busy_o,
                       ph_consume_v_o, nph_consume_v_o, cplh_consume_v_o,
                       pd_consume_v_o, npd_consume_v_o, cpld_consume_v_o,
                       ph_consume_dw_o, nph_consume_dw_o, cplh_consume_dw_o,
                       pd_consume_dw_o, npd_consume_dw_o, cpld_consume_dw_o};

    // Expected output vector: grant g, whether this is the grant's first cycle, and its data credits.
    function automatic logic [69:0] mk(input logic [2:0] g, input logic first, input logic [11:0] d);
        logic [2:0] hv, dv;
        hv = first ? g : 3'b000;
        dv = (d != 12'd0) ? hv : 3'b000;
        mk = {g, |g, hv[0], hv[1], hv[2], dv[0], dv[1], dv[2],
              hv[0] ? 8'd1 : 8'd0, hv[1] ? 8'd1 : 8'd0, hv[2] ? 8'd1 : 8'd0,
              dv[0] ? d : 12'd0, dv[1] ? d : 12'd0, dv[2] ? d : 12'd0};
    endfunction

    task automatic test_reset();
        logic [69:0] e;
        rst_n = 1'b0; arb_en_i = 1'b1;
        p_req_i = 1'b1; np_req_i = 1'b1; cpl_req_i = 1'b1;
        p_dcred_i = '0; np_dcred_i = '0; cpl_dcred_i = '0;
        ph_ok_i = 1'b1; pd_ok_i = 1'b1; nph_ok_i = 1'b1;
        npd_ok_i = 1'b1; cplh_ok_i = 1'b1; cpld_ok_i = 1'b1;
        tx_done_i = 1'b0;
        e = mk(3'b000, 1'b0, 12'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, e);
            end
        end
        p_req_i = 1'b0; np_req_i = 1'b0; cpl_req_i = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_rr_order();
        logic [2:0]  g [3] = '{3'b001, 3'b010, 3'b100};
        logic [11:0] d [3] = '{12'd4, 12'd0, 12'd2};
        logic [69:0] e;
        p_req_i = 1'b1; np_req_i = 1'b1; cpl_req_i = 1'b1;
        p_dcred_i = 12'd4; np_dcred_i = 12'd0; cpl_dcred_i = 12'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = mk(g[k], 1'b1, d[k]);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rr_grant[%0d]: got %h want %h", k, obs, e); end
            @(negedge clk);
            e = mk(g[k], 1'b0, d[k]);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rr_hold[%0d]: got %h want %h", k, obs, e); end
            tx_done_i = 1'b1;
            if (k == 2) begin p_req_i = 1'b0; np_req_i = 1'b0; cpl_req_i = 1'b0; end
            @(negedge clk);
            e = mk(3'b000, 1'b0, 12'd0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rr_gap[%0d]: got %h want %h", k, obs, e); end
            tx_done_i = 1'b0;
        end
    endtask

    task automatic test_pd_block();
        logic [69:0] e;
        p_req_i = 1'b1; p_dcred_i = 12'd4; pd_ok_i = 1'b0;
        np_req_i = 1'b1; np_dcred_i = 12'd0;
        @(negedge clk);
        e = mk(3'b010, 1'b1, 12'd0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL pd_block_np: got %h want %h", obs, e); end
        tx_done_i = 1'b1; pd_ok_i = 1'b1; np_req_i = 1'b0;
        @(negedge clk);
        e = mk(3'b000, 1'b0, 12'd0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL pd_block_gap: got %h want %h", obs, e); end
        tx_done_i = 1'b0;
        @(negedge clk);
        e = mk(3'b001, 1'b1, 12'd4);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL pd_block_p: got %h want %h", obs, e); end
        tx_done_i = 1'b1; p_req_i = 1'b0;
        @(negedge clk);
        e = mk(3'b000, 1'b0, 12'd0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL pd_block_end: got %h want %h", obs, e); end
        tx_done_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] g [6] = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        logic [69:0] e;
        p_req_i = 1'b1; np_req_i = 1'b1; cpl_req_i = 1'b1;
        p_dcred_i = '0; np_dcred_i = '0; cpl_dcred_i = '0;
        tx_done_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = mk(g[k], 1'b1, 12'd0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL b2b[%0d]: got %h want %h", k, obs, e); end
        end
        p_req_i = 1'b0; np_req_i = 1'b0; cpl_req_i = 1'b0;
        tx_done_i = 1'b0;
    endtask

    task automatic test_arb_en();
        logic [69:0] e;
        cpl_req_i = 1'b1; cpl_dcred_i = 12'd2;
        @(negedge clk);
        e = mk(3'b100, 1'b1, 12'd2);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL arb_en_grant: got %h want %h", obs, e); end
        arb_en_i = 1'b0;
        @(negedge clk);
        e = mk(3'b100, 1'b0, 12'd2);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL arb_en_hold: got %h want %h", obs, e); end
        tx_done_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = mk(3'b000, 1'b0, 12'd0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL arb_en_off[%0d]: got %h want %h", k, obs, e); end
            tx_done_i = 1'b0;
        end
        arb_en_i = 1'b1;
        @(negedge clk);
        e = mk(3'b100, 1'b1, 12'd2);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL arb_en_regrant: got %h want %h", obs, e); end
    endtask

    task automatic test_reset_mid();
        logic [69:0] e;
        p_req_i = 1'b1; np_req_i = 1'b1; cpl_req_i = 1'b1;
        p_dcred_i = 12'd4; np_dcred_i = 12'd0; cpl_dcred_i = 12'd2;
        @(negedge clk);
        e = mk(3'b100, 1'b0, 12'd2);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rst_mid_hold: got %h want %h", obs, e); end
        #2 rst_n = 1'b0;
        #1;
        e = mk(3'b000, 1'b0, 12'd0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rst_mid_async: got %h want %h", obs, e); end
        @(negedge clk);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rst_mid_held: got %h want %h", obs, e); end
        rst_n = 1'b1;
        @(negedge clk);
        e = mk(3'b001, 1'b1, 12'd4);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rst_mid_first: got %h want %h", obs, e); end
        tx_done_i = 1'b1;
        p_req_i = 1'b0; np_req_i = 1'b0; cpl_req_i = 1'b0;
        @(negedge clk);
        e = mk(3'b000, 1'b0, 12'd0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rst_mid_end: got %h want %h", obs, e); end
        tx_done_i = 1'b0;
    endtask

    task automatic test_cpl_toggle();
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [69:0] e;
        cpl_req_i = 1'b1; cpl_dcred_i = 12'd3; tx_done_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cpld_ok_i = pat[k];
            @(negedge clk);
            e = pat[k] ? mk(3'b100, 1'b1, 12'd3) : mk(3'b000, 1'b0, 12'd0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL cpl_tog_arb[%0d]: got %h want %h", k, obs, e); end
            cpld_ok_i = 1'b0;
            @(negedge clk);
            e = mk(3'b000, 1'b0, 12'd0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL cpl_tog_gap[%0d]: got %h want %h", k, obs, e); end
        end
        cpl_req_i = 1'b0; tx_done_i = 1'b0; cpld_ok_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_pd_block();
        test_back_to_back();
        test_arb_en();
        test_reset_mid();
        test_cpl_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
